// File: rtl/aes_pkg.sv
// Shared AES datapath types and byte-permutation helpers for the forward and
// inverse round stages.
package aes_pkg;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Byte bN sits at s[127-8N -: 8]; column c holds rows 0..3 as b4c..b4c+3.
    function automatic aes_state_t shiftrows_f(input aes_state_t s);
        aes_state_t r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic aes_state_t inv_shiftrows_f(input aes_state_t s);
        aes_state_t r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+4-row)%4)+row) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_skid_buffer.sv
// Valid/ready pipeline buffer reused by the AES round stages: two entries with
// a registered i_ready (SKID=1), or a single register (SKID=0).
module aes_skid_buffer
    import aes_pkg::*;
#(
    parameter int SKID = 1,
    parameter int W    = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [W-1:0] i_data,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [W-1:0] o_data,
    output skid_state_t dbg_state
);

    // Handshake: a beat moves on a rising edge when valid && ready on that
    // side; valid never waits on ready, and data only changes after a transfer.
    generate
        if (SKID == 1) begin : g_skid
            skid_state_t  state_q, state_d;
            logic [W-1:0] main_q, skid_q;
            logic         accept, drain;
            logic         load_main_in, load_main_skid, load_skid;

            assign i_ready   = (state_q != FULL);
            assign o_valid   = (state_q != EMPTY);
            assign o_data    = main_q;
            assign dbg_state = state_q;
            assign accept    = i_valid && i_ready;
            assign drain     = o_valid && o_ready;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) state_q <= EMPTY;
                else      state_q <= state_d;
            end

            always_comb begin
                state_d        = state_q;
                load_main_in   = 1'b0;
                load_main_skid = 1'b0;
                load_skid      = 1'b0;
                case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            state_d      = ONE;
                            load_main_in = 1'b1;
                        end
                    end
                    ONE: begin
                        if (accept && !drain) begin
                            state_d   = FULL;
                            load_skid = 1'b1;
                        end else if (accept && drain) begin
                            load_main_in = 1'b1;
                        end else if (drain) begin
                            state_d = EMPTY;
                        end
                    end
                    FULL: begin
                        if (drain) begin
                            state_d        = ONE;
                            load_main_skid = 1'b1;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end

            // Data only moves on an enable, so an idle i_data never reaches storage.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    main_q <= '0;
                    skid_q <= '0;
                end else begin
                    if (load_main_in)        main_q <= i_data;
                    else if (load_main_skid) main_q <= skid_q;
                    if (load_skid)           skid_q <= i_data;
                end
            end
        end else begin : g_single
            logic         valid_q;
            logic [W-1:0] data_q;

            assign i_ready   = o_ready || !valid_q;
            assign o_valid   = valid_q;
            assign o_data    = data_q;
            assign dbg_state = valid_q ? ONE : EMPTY;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else if (i_valid && i_ready) begin
                    valid_q <= 1'b1;
                    data_q  <= i_data;
                end else if (o_ready) begin
                    valid_q <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/inv_shiftrows.sv
// AES InvShiftRows pipeline stage: the byte permutation is applied on the way
// in, so every buffered entry is already transformed.
module inv_shiftrows
    import aes_pkg::*;
#(
    parameter int SKID = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [127:0]  i_block,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [127:0]  o_block,
    output skid_state_t   dbg_state
);

    aes_state_t t_block;

    assign t_block = inv_shiftrows_f(i_block);

    aes_skid_buffer #(
        .SKID (SKID),
        .W    (128)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_data    (t_block),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_data    (o_block),
        .dbg_state (dbg_state)
    );

endmodule

// File: tb/tb_inv_shiftrows.sv
// Bench for inv_shiftrows: SKID=1 and SKID=0 instances, scoreboard queues per
// instance fed by the drivers and drained by independent monitors.
`timescale 1ns/1ps
module tb_inv_shiftrows;
    import aes_pkg::*;

    logic         clk;
    logic         rst;
    logic         iv0, ir0, ov0, ordy0;
    logic         iv1, ir1, ov1, ordy1;
    logic [127:0] ib0, ob0, ib1, ob1;
    skid_state_t  dbg0, dbg1;

    logic [127:0] exp_q0[$];
    logic [127:0] exp_q1[$];
    int           drain_cyc1[$];
    int           n_checks;
    int           n_errors;
    int           cyc;
    int           drain_cnt0, drain_cnt1;
    bit           tog_en;
    bit           prev_stall0, prev_stall1;
    logic [127:0] held0, held1;

    inv_shiftrows #(.SKID(1)) dut_skid (
        .clk(clk), .rst(rst), .i_valid(iv1), .i_ready(ir1), .i_block(ib1),
        .o_valid(ov1), .o_ready(ordy1), .o_block(ob1), .dbg_state(dbg1)
    );

    inv_shiftrows #(.SKID(0)) dut_noskid (
        .clk(clk), .rst(rst), .i_valid(iv0), .i_ready(ir0), .i_block(ib0),
        .o_valid(ov0), .o_ready(ordy0), .o_block(ob0), .dbg_state(dbg0)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Output row r, column c takes input row r, column (c - r) mod 4.
    function automatic logic [127:0] ref_inv(input logic [127:0] s);
        logic [7:0]   m [4][4];
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                m[row][c] = s[127-8*(4*c+row) -: 8];
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[127-8*(4*c+row) -: 8] = m[row][(c - row + 4) % 4];
        return r;
    endfunction

    function automatic logic [127:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input int ch, input logic [127:0] blk, input logic [127:0] exp,
                        output int waits);
        bit done;
        done  = 0;
        waits = 0;
        if (ch == 0) begin iv0 = 1'b1; ib0 = blk; end
        else         begin iv1 = 1'b1; ib1 = blk; end
        while (!done && waits < 200) begin
            @(negedge clk);
            if (rst && ((ch == 0) ? ir0 : ir1)) begin
                if (ch == 0) exp_q0.push_back(exp);
                else         exp_q1.push_back(exp);
                done = 1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        if (ch == 0) begin iv0 = 1'b0; ib0 = rand_block(); end
        else         begin iv1 = 1'b0; ib1 = rand_block(); end
        if (!done) check("send_timeout", 128'(waits), 128'd0);
    endtask

    task automatic send_t(input int ch, input logic [127:0] blk);
        int w;
        send(ch, blk, ref_inv(blk), w);
    endtask

    task automatic wait_empty(input int ch);
        int n;
        n = 0;
        while (((ch == 0) ? exp_q0.size() : exp_q1.size()) != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("drain_timeout", 128'(n), 128'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall1 = 1'b0;
        end else begin
            if (prev_stall1) check("hold_skid", ob1, held1);
            if (ov1 && ordy1) begin
                drain_cnt1++;
                drain_cyc1.push_back(cyc);
                if (exp_q1.size() == 0) check("unexpected_out_skid", ob1, 128'd0 - 1);
                else                    check("out_skid", ob1, exp_q1.pop_front());
            end
            prev_stall1 = ov1 && !ordy1;
            held1       = ob1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall0 = 1'b0;
        end else begin
            check("iready_comb_noskid", 128'(ir0), 128'(ordy0 || !ov0));
            if (prev_stall0) check("hold_noskid", ob0, held0);
            if (ov0 && ordy0) begin
                drain_cnt0++;
                if (exp_q0.size() == 0) check("unexpected_out_noskid", ob0, 128'd0 - 1);
                else                    check("out_noskid", ob0, exp_q0.pop_front());
            end
            prev_stall0 = ov0 && !ordy0;
            held0       = ob0;
        end
    end

    always @(posedge clk) begin
        if (tog_en) begin
            #1;
            ordy1 = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] b1, b2, b3, orig;
        int           w, stalls, d0;

        n_checks = 0; n_errors = 0; drain_cnt0 = 0; drain_cnt1 = 0; cyc = 0;
        tog_en = 0; prev_stall0 = 0; prev_stall1 = 0; held0 = '0; held1 = '0;
        rst = 1'b0; iv0 = 0; iv1 = 1'b1; ib0 = '0; ib1 = rand_block();
        ordy0 = 0; ordy1 = 1;

        // Reset state (i_valid asserted on the skid instance must be ignored).
        repeat (3) @(posedge clk);
        #1;
        check("rst_ovalid_skid", 128'(ov1), 128'd0);
        check("rst_oblock_skid", ob1, 128'd0);
        check("rst_iready_skid", 128'(ir1), 128'd1);
        check("rst_state_skid", 128'(dbg1), 128'(EMPTY));
        check("rst_ovalid_noskid", 128'(ov0), 128'd0);
        check("rst_iready_noskid", 128'(ir0), 128'd1);
        iv1 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Counting pattern with a one-cycle latency check.
        send(1, 128'h00010203_04050607_08090A0B_0C0D0E0F,
             128'h000D0A07_04010E0B_0805020F_0C090603, w);
        check("count_latency_valid", 128'(ov1), 128'd1);
        check("count_latency_data", ob1, 128'h000D0A07_04010E0B_0805020F_0C090603);
        wait_empty(1);

        // Round trip: fixed vector, then random states through the forward permutation.
        send(1, 128'h00112233_10213203_20310213_30011223,
             128'h00010203_10111213_20212223_30313233, w);
        for (int i = 0; i < 64; i++) begin
            orig = rand_block();
            send(1, shiftrows_f(orig), orig, w);
        end
        wait_empty(1);

        // Backpressure: two accepts fill the buffer, third must wait.
        b1 = rand_block(); b2 = rand_block(); b3 = rand_block();
        ordy1 = 0;
        send_t(1, b1);
        send_t(1, b2);
        iv1 = 1'b1; ib1 = b3;
        @(negedge clk);
        check("bp_iready_low", 128'(ir1), 128'd0);
        check("bp_state_full", 128'(dbg1), 128'(FULL));
        check("bp_head", ob1, ref_inv(b1));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        ordy1 = 1;
        @(negedge clk);
        check("bp_iready_still_low", 128'(ir1), 128'd0);
        @(posedge clk);
        #1;
        check("bp_iready_rise", 128'(ir1), 128'd1);
        send_t(1, b3);
        wait_empty(1);

        // Streaming: 32 back-to-back blocks with no stalls and no output bubbles.
        ordy1 = 1; stalls = 0; d0 = drain_cyc1.size();
        for (int i = 0; i < 32; i++) begin
            b1 = rand_block();
            send(1, b1, ref_inv(b1), w);
            stalls += w;
        end
        @(negedge clk);
        #1;
        check("stream_stalls", 128'(stalls), 128'd0);
        check("stream_count", 128'(drain_cyc1.size() - d0), 128'd32);
        if (drain_cyc1.size() >= d0 + 32)
            check("stream_span", 128'(drain_cyc1[d0+31] - drain_cyc1[d0]), 128'd31);
        @(posedge clk);
        #1;

        // Random valid gaps and random downstream readiness.
        tog_en = 1;
        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_t(1, rand_block());
        end
        tog_en = 0;
        @(posedge clk);
        #2;
        ordy1 = 1;
        wait_empty(1);

        // Asynchronous reset while full: outputs clear with no clock edge.
        ordy1 = 0;
        send_t(1, rand_block());
        send_t(1, rand_block());
        #2;
        rst = 1'b0;
        #1;
        check("midrst_ovalid", 128'(ov1), 128'd0);
        check("midrst_oblock", ob1, 128'd0);
        check("midrst_iready", 128'(ir1), 128'd1);
        check("midrst_state", 128'(dbg1), 128'(EMPTY));
        exp_q1.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        ordy1 = 1;
        b1 = rand_block();
        send(1, b1, ref_inv(b1), w);
        check("postrst_first_accept_waits", 128'(w), 128'd0);
        wait_empty(1);
        repeat (3) @(posedge clk);
        #1;
        check("postrst_no_stale", 128'(ov1), 128'd0);

        // Single-register variant under the same backpressure scenario.
        b1 = rand_block(); b2 = rand_block(); b3 = rand_block();
        ordy0 = 0;
        send_t(0, b1);
        iv0 = 1'b1; ib0 = b2;
        #1;
        check("s0_iready_blocked", 128'(ir0), 128'd0);
        ordy0 = 1;
        #1;
        check("s0_iready_follows", 128'(ir0), 128'd1);
        send_t(0, b2);
        ordy0 = 0;
        iv0 = 1'b1; ib0 = b3;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        ordy0 = 1;
        send_t(0, b3);
        wait_empty(0);
        check("s0_drains", 128'(drain_cnt0), 128'd3);

        check("final_q_skid", 128'(exp_q1.size()), 128'd0);
        check("final_q_noskid", 128'(exp_q0.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
